// File: rtl/line_drawer.sv
// Bresenham line rasteriser feeding the VGA adapter: one pixel per clock,
// endpoints clamped to the frame, busy while drawing, done pulse at the end.
module line_drawer #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] XMAX = 8'(SCREEN_WIDTH - 1);
    localparam logic [6:0] YMAX = 7'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    state_t            state_q;
    logic [7:0]        x0_q, x1_q, x_q;
    logic [6:0]        y0_q, y1_q, y_q;
    logic [2:0]        colour_q;
    logic signed [8:0] dx_q, dy_q;
    logic              sx_neg_q, sy_neg_q;
    logic signed [9:0] err_q;
    logic              plot_q, busy_q, done_q;

    logic [7:0]         adx, x_d;
    logic [6:0]         ady, y_d;
    logic signed [8:0]  dx_d, dy_d;
    logic signed [9:0]  err_init, err_d, dx_w, dy_w;
    logic signed [10:0] e2, dx_e, dy_e;
    logic               step_x, step_y, at_end;

    always_comb begin
        adx      = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
        ady      = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
        dx_d     = $signed({1'b0, adx});
        dy_d     = 9'sd0 - $signed({2'b00, ady});
        err_init = $signed({dx_d[8], dx_d}) + $signed({dy_d[8], dy_d});

        dx_w = $signed({dx_q[8], dx_q});
        dy_w = $signed({dy_q[8], dy_q});
        dx_e = $signed({{2{dx_q[8]}}, dx_q});
        dy_e = $signed({{2{dy_q[8]}}, dy_q});
        e2   = $signed({err_q, 1'b0});

        // Both step decisions use the same e2, taken before err is updated.
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);

        err_d = err_q;
        x_d   = x_q;
        y_d   = y_q;
        if (step_x) begin
            err_d = err_d + dy_w;
            x_d   = sx_neg_q ? x_q - 8'd1 : x_q + 8'd1;
        end
        if (step_y) begin
            err_d = err_d + dx_w;
            y_d   = sy_neg_q ? y_q - 7'd1 : y_q + 7'd1;
        end

        at_end = (x_q == x1_q) && (y_q == y1_q);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x0_q     <= (x0 > XMAX) ? XMAX : x0;
                        x1_q     <= (x1 > XMAX) ? XMAX : x1;
                        y0_q     <= (y0 > YMAX) ? YMAX : y0;
                        y1_q     <= (y1 > YMAX) ? YMAX : y1;
                        colour_q <= colour_in;
                        busy_q   <= 1'b1;
                        state_q  <= INIT;
                    end
                end
                INIT: begin
                    dx_q     <= dx_d;
                    dy_q     <= dy_d;
                    sx_neg_q <= !(x0_q < x1_q);
                    sy_neg_q <= !(y0_q < y1_q);
                    err_q    <= err_init;
                    x_q      <= x0_q;
                    y_q      <= y0_q;
                    plot_q   <= 1'b1;
                    state_q  <= DRAW;
                end
                DRAW: begin
                    if (at_end) begin
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        err_q <= err_d;
                        x_q   <= x_d;
                        y_q   <= y_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
